// File: rtl/wb_initiator.sv
// wb_initiator: Wishbone classic single-transfer initiator.
//
// Takes one command at a time on a valid/ready port, runs it as a single
// Wishbone classic cycle, waits for ack (bounded by TIMEOUT cycles) and
// returns read data or a timeout error on a valid/ready response port.
//
// Ports:
//   wb_clk_i, wb_rst_n_i     clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o  command handshake
//   cmd_we_i/adr_i/dat_i/sel_i  command fields (1 = write)
//   rsp_valid_o/rsp_ready_i  response handshake
//   rsp_dat_o/rsp_err_o      read data (0 for writes/timeouts), timeout flag
//   wbm_*                    Wishbone initiator signals
//   txn_count_o              completed transactions (wrapping)
//   err_count_o              timeouts (saturating)

`timescale 1ns/1ps

module wb_initiator #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [31:0] cmd_adr_i,
    input  logic [31:0] cmd_dat_i,
    input  logic [3:0]  cmd_sel_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_dat_o,
    output logic        rsp_err_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i,
    output logic [15:0] txn_count_o,
    output logic [7:0]  err_count_o
);

    typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

    // Last BUS-cycle index (0-based) before the transfer is abandoned.
    localparam logic [7:0] TmoLast = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        cyc_q, cyc_d;
    logic        we_q, we_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [3:0]  sel_q, sel_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_dat_q, rsp_dat_d;
    logic        rsp_err_q, rsp_err_d;
    logic [7:0]  tmo_q, tmo_d;
    logic [15:0] txn_q, txn_d;
    logic [7:0]  err_q, err_d;

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
        tmo_d       = tmo_q;
        txn_d       = txn_q;
        err_d       = err_q;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid_i && cmd_ready_q) begin
                    state_d     = StBus;
                    cmd_ready_d = 1'b0;
                    cyc_d       = 1'b1;
                    we_d        = cmd_we_i;
                    adr_d       = cmd_adr_i;
                    dat_d       = cmd_dat_i;
                    sel_d       = cmd_sel_i;
                    tmo_d       = 8'd0;
                end
            end
            StBus: begin
                // Ack wins over timeout, so an ack in the last allowed cycle succeeds.
                if (wbm_ack_i) begin
                    state_d     = StResp;
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = we_q ? 32'd0 : wbm_dat_i;
                    rsp_err_d   = 1'b0;
                    txn_d       = txn_q + 16'd1;
                end else if (tmo_q == TmoLast) begin
                    state_d     = StResp;
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = 32'd0;
                    rsp_err_d   = 1'b1;
                    txn_d       = txn_q + 16'd1;
                    if (err_q != 8'hFF) begin
                        err_d = err_q + 8'd1;
                    end
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            StResp: begin
                if (rsp_ready_i) begin
                    state_d     = StIdle;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end
            default: begin
                state_d     = StIdle;
                cmd_ready_d = 1'b1;
                cyc_d       = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q     <= StIdle;
            cmd_ready_q <= 1'b1;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= 32'd0;
            dat_q       <= 32'd0;
            sel_q       <= 4'd0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= 32'd0;
            rsp_err_q   <= 1'b0;
            tmo_q       <= 8'd0;
            txn_q       <= 16'd0;
            err_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
            tmo_q       <= tmo_d;
            txn_q       <= txn_d;
            err_q       <= err_d;
        end
    end

    assign cmd_ready_o = cmd_ready_q;
    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = cyc_q;
    assign wbm_we_o    = we_q;
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = dat_q;
    assign wbm_sel_o   = sel_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_dat_o   = rsp_dat_q;
    assign rsp_err_o   = rsp_err_q;
    assign txn_count_o = txn_q;
    assign err_count_o = err_q;

endmodule

// File: tb/tb_wb_initiator.sv
// Testbench for wb_initiator: the bench plays the Wishbone slave and keeps a
// transaction-level model of responses and counters.

`timescale 1ns/1ps

module tb_wb_initiator;

    localparam int unsigned TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_adr = '0;
    logic [31:0] cmd_dat = '0;
    logic [3:0]  cmd_sel = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        wbm_cyc, wbm_stb, wbm_we;
    logic [31:0] wbm_adr, wbm_dat;
    logic [3:0]  wbm_sel;
    logic        wbm_ack = 1'b0;
    logic [31:0] wbm_rdat = '0;
    logic [15:0] txn_count;
    logic [7:0]  err_count;

    int n_cmp = 0;
    int n_fail = 0;

    // Transaction-level model of the counters.
    logic [15:0] mdl_txn = '0;
    int          mdl_err = 0;

    wb_initiator #(.TIMEOUT(TMO)) dut (
        .wb_clk_i    (clk),
        .wb_rst_n_i  (rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_we_i    (cmd_we),
        .cmd_adr_i   (cmd_adr),
        .cmd_dat_i   (cmd_dat),
        .cmd_sel_i   (cmd_sel),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_dat_o   (rsp_dat),
        .rsp_err_o   (rsp_err),
        .wbm_cyc_o   (wbm_cyc),
        .wbm_stb_o   (wbm_stb),
        .wbm_we_o    (wbm_we),
        .wbm_adr_o   (wbm_adr),
        .wbm_dat_o   (wbm_dat),
        .wbm_sel_o   (wbm_sel),
        .wbm_ack_i   (wbm_ack),
        .wbm_dat_i   (wbm_rdat),
        .txn_count_o (txn_count),
        .err_count_o (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_counters(input string tag);
        chk({tag, "_txn"}, 128'(txn_count), 128'(mdl_txn));
        chk({tag, "_err"}, 128'(err_count), 128'(mdl_err));
    endtask

    // One full transfer. ack_at = BUS cycle (1-based) in which the slave acks,
    // 0 = never. hold = cycles of response backpressure. Called at a negedge
    // with the initiator idle.
    task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input int ack_at, input logic [31:0] rdat,
                           input int hold);
        int          stb_cycles;
        bit          ok;
        logic [31:0] exp_dat;
        logic        exp_err;
        chk("cmd_ready_idle", 128'(cmd_ready), 128'(1));
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = sel;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_adr   = $urandom;
        cmd_dat   = $urandom;
        stb_cycles = 0;
        for (int c = 1; c <= int'(TMO) + 2; c++) begin
            if (!wbm_stb) break;
            stb_cycles++;
            chk("bus_fields", {wbm_cyc, wbm_we, wbm_adr, wbm_dat, wbm_sel},
                {1'b1, we, adr, dat, sel});
            chk("cmd_ready_bus", 128'(cmd_ready), 128'(0));
            wbm_ack  = (c == ack_at);
            wbm_rdat = (c == ack_at) ? rdat : $urandom;
            @(negedge clk);
        end
        wbm_ack = 1'b0;
        ok      = (ack_at >= 1) && (ack_at <= int'(TMO));
        exp_err = !ok;
        exp_dat = (!ok || we) ? 32'd0 : rdat;
        mdl_txn = mdl_txn + 16'd1;
        if (!ok && mdl_err < 255) mdl_err++;
        chk("stb_cycles", 128'(stb_cycles), 128'(ok ? ack_at : int'(TMO)));
        chk("rsp_first", {rsp_valid, rsp_err, rsp_dat, wbm_cyc}, {1'b1, exp_err, exp_dat, 1'b0});
        chk_counters("cnt_done");
        for (int h = 0; h < hold; h++) begin
            // Stray acks while waiting for the consumer must be ignored.
            wbm_ack  = $urandom_range(0, 1);
            wbm_rdat = $urandom;
            @(negedge clk);
            chk("rsp_hold", {rsp_valid, rsp_err, rsp_dat, cmd_ready, wbm_cyc},
                {1'b1, exp_err, exp_dat, 1'b0, 1'b0});
        end
        wbm_ack = 1'b0;
        chk_counters("cnt_hold");
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("after_rsp", {cmd_ready, rsp_valid, wbm_cyc}, {1'b1, 1'b0, 1'b0});
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_ctl"}, {cmd_ready, rsp_valid, rsp_err, wbm_cyc, wbm_stb, wbm_we},
            {1'b1, 5'b0});
        chk({tag, "_data"}, {rsp_dat, wbm_adr, wbm_dat, wbm_sel}, 128'(0));
        chk({tag, "_cnt"}, {txn_count, err_count}, 128'(0));
    endtask

    initial begin
        logic [31:0] a, d;
        // Reset.
        #12 chk_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_values("post_reset");

        // Write, ack in 3rd stb cycle.
        run_txn(1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF, 3, 32'hFFFF_FFFF, 0);
        chk("write_txn1", 128'(txn_count), 128'(1));
        // Read, ack in first cycle.
        run_txn(1'b0, 32'h3000_0010, 32'h0, 4'hF, 1, 32'hDEAD_C0DE, 0);
        // Timeout, then ack in the TIMEOUT-th cycle.
        run_txn(1'b0, 32'h3000_0020, 32'h0, 4'h3, 0, 32'h1234_5678, 0);
        chk("timeout_err1", 128'(err_count), 128'(1));
        run_txn(1'b0, 32'h3000_0024, 32'h0, 4'hF, int'(TMO), 32'h0BAD_F00D, 0);
        // Read with 10 cycles of backpressure.
        run_txn(1'b0, 32'h3000_0030, 32'h0, 4'hF, 2, 32'hCAFE_BABE, 10);

        // Randomized transfers.
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            d = $urandom;
            run_txn(1'($urandom_range(0, 1)), a, d, 4'($urandom), $urandom_range(0, int'(TMO) + 2),
                    $urandom, $urandom_range(0, 3));
        end

        // Reset in the 2nd stb cycle.
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_adr   = 32'h3000_0040;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("pre_reset_stb", 128'(wbm_stb), 128'(1));
        #2 rst_n = 1'b0;
        #1 chk("async_drop", {wbm_cyc, wbm_stb}, 128'(0));
        @(negedge clk);
        chk_reset_values("mid_reset");
        rst_n   = 1'b1;
        mdl_txn = '0;
        mdl_err = 0;
        @(negedge clk);
        run_txn(1'b0, 32'h3000_0044, 32'h0, 4'hF, 2, 32'h600D_0001, 1);

        // 256 timeouts: err_count saturates.
        for (int i = 0; i < 256; i++) begin
            run_txn(1'b0, 32'h3000_1000 + 32'(i), 32'h0, 4'hF, 0, 32'h0, 0);
        end
        chk("err_saturated", 128'(err_count), 128'(8'hFF));

        // txn_count wrap from a preloaded value.
        force dut.txn_q = 16'hFFFF;
        @(negedge clk);
        release dut.txn_q;
        @(negedge clk);
        chk("preload", 128'(txn_count), 128'(16'hFFFF));
        mdl_txn = 16'hFFFF;
        run_txn(1'b0, 32'h3000_2000, 32'h0, 4'hF, 1, 32'h7777_0000, 0);
        chk("txn_wrapped", 128'(txn_count), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_initiator.md
# wb_initiator

Wishbone classic single-transfer initiator that drives the user-area slave bus from a simple valid/ready command port, so on-chip sequencers and LA-driven test logic can exercise the macros' Wishbone slave ports without the management SoC. It is the initiator end of the Wishbone interface the user macros implement as responders. It issues one read or write at a time, waits for `ack`, aborts on a bounded timeout, and returns data or error on a valid/ready response port.

## Interface
Parameters:
- `TIMEOUT`, 255: number of cycles with `wbm_stb_o` high and no ack before abort; legal range 1..255.

Ports:
- `wb_clk_i`  in  1  bus clock; single clock domain.
- `wb_rst_n_i`  in  1  reset, asynchronous, active-low.
- `cmd_valid_i`  in  1  command present.
- `cmd_ready_o`  out  1  command accepted when high with `cmd_valid_i`.
- `cmd_we_i`  in  1  1 = write, 0 = read.
- `cmd_adr_i`  in  32  byte address.
- `cmd_dat_i`  in  32  write data.
- `cmd_sel_i`  in  4  byte lane selects.
- `rsp_valid_o`  out  1  response present.
- `rsp_ready_i`  in  1  response consumed when high with `rsp_valid_o`.
- `rsp_dat_o`  out  32  read data. Writes return 0. Timeouts return 0.
- `rsp_err_o`  out  1  1 = transaction timed out.
- `wbm_cyc_o`, `wbm_stb_o`, `wbm_we_o`  out  1 each  Wishbone controls.
- `wbm_adr_o` out 32, `wbm_dat_o` out 32, `wbm_sel_o` out 4  Wishbone address, data and selects.
- `wbm_ack_i`  in  1  slave acknowledge.
- `wbm_dat_i`  in  32  slave read data.
- `txn_count_o`  out  16  completed transactions; wraps at 16'hFFFF→0.
- `err_count_o`  out  8  timeouts; saturates at 8'hFF.

## Operation
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - `cmd_ready_o`=1 and all Wishbone controls are 0.
  - On `cmd_valid_i`&`cmd_ready_o`, latch we/adr/dat/sel and go to BUS.
- BUS:
  - `wbm_cyc_o`=`wbm_stb_o`=1. Bus outputs are driven from latched registers and held stable for the whole cycle.
  - The timeout counter clears on entry and increments each BUS cycle without `wbm_ack_i`.
  - On `wbm_ack_i`=1: capture `wbm_dat_i` if a read (0 if a write), set `rsp_err`=0, increment `txn_count`, go to RESP.
  - If TIMEOUT consecutive BUS cycles pass without ack: set `rsp_dat`=0, `rsp_err`=1, increment both counters, go to RESP.
  - An ack in the TIMEOUT-th cycle counts as success.
- RESP:
  - `rsp_valid_o`=1; `rsp_dat_o`/`rsp_err_o` are held stable.
  - Bus controls are 0.
  - On `rsp_ready_i`, go to IDLE.
- `wbm_ack_i` in IDLE or RESP is ignored: no state or counter change.
- `wbm_adr_o`/`wbm_dat_o`/`wbm_sel_o`/`wbm_we_o` retain their last values outside BUS.
- Reset at any point, including mid-BUS: asynchronous return to IDLE. Bus controls drop immediately; counters clear.

## Timing
- All outputs are registered.
- Reset values:
  - `cmd_ready_o`=1 (once reset is released).
  - All other outputs are 0: `rsp_valid_o`, `rsp_err_o`, `rsp_dat_o`, `wbm_cyc_o`, `wbm_stb_o`, `wbm_we_o`, `wbm_adr_o`, `wbm_dat_o`, `wbm_sel_o`, `txn_count_o`, `err_count_o`.
- Command accepted at edge 0 → `wbm_cyc_o`/`wbm_stb_o` high from cycle 1.
- Ack sampled at edge k → `cyc`/`stb` low and `rsp_valid_o` high from cycle k+1.
- Minimum command-to-response latency: 2 cycles (ack in the first BUS cycle).
- Timeout: `stb` high in cycles 1..TIMEOUT; with no ack, `rsp_valid_o`=1 with `rsp_err_o`=1 from cycle TIMEOUT+1.
- Response handshake at edge r → `cmd_ready_o` high from cycle r+1. Back-to-back throughput is one transfer per 3 cycles minimum.
- `cmd_ready_o` is 0 in BUS and RESP.
- Counters update on the same edge as the BUS→RESP transition.

## Test plan
- Write: cmd we=1, adr=0x3000_0004, dat=0xA5A5_1234, sel=0xF; slave acks on the 3rd stb cycle. Required:
  - the slave sees exactly those values with cyc=stb=we=1 for 3 cycles;
  - rsp_valid then has rsp_dat=0 and rsp_err=0;
  - txn_count=1.
- Read: cmd we=0, adr=0x3000_0010; slave returns 0xDEAD_C0DE with ack in the first cycle. Required: rsp_valid 2 cycles after accept with rsp_dat=0xDEAD_C0DE and rsp_err=0.
- Timeout, TIMEOUT=4, slave never acks. Required:
  - stb high for exactly 4 cycles;
  - rsp_err=1, rsp_dat=0;
  - err_count=1, txn_count=1.
  - Repeat with an ack in the 4th cycle: required rsp_err=0.
- Backpressure: hold rsp_ready=0 for 10 cycles after a read. Required:
  - rsp_valid/rsp_dat stay stable;
  - cmd_ready=0 and a stray ack causes no change;
  - cmd_ready=1 the cycle after rsp_ready.
- Reset mid-BUS: assert wb_rst_n_i=0 asynchronously in the 2nd stb cycle. Required: cyc/stb drop without waiting for a clock edge, all outputs reach reset values, and the next command completes normally.
- Counter wrap and saturation, using a preloaded or long run:
  - txn_count 0xFFFF → 0 on the next completion;
  - 256 timeouts leave err_count at 0xFF.
